block_sel_seq: RTL
==================

Name: block_sel_seq

Overview:
- Sequencer that drives the S0/S1 select pair of the two-lane gating block (O0/O1 driven low or with ~I1).
- Steps through a small programmed table of 2-bit select codes, holding each for a programmable number of cycles.
- Supports one-shot and looping runs with a start/stop/busy/done handshake.
- Sits between the control/config logic and the gating block; the gating block itself stays combinational.

Parameters:
- DEPTH, 4, number of table entries; power of two, 2..16; AW = $clog2(DEPTH) is derived internally.
- DW, 8, width of the dwell counter and of the dwell input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- prog_we  input  1  table write strobe.
- prog_addr  input  AW  table entry index for the write.
- prog_code  input  2  select code to store; bit1 maps to s0, bit0 maps to s1.
- dwell  input  DW  hold cycles per entry; sampled at start.
- loop_en  input  1  1 = wrap to entry 0 after the last entry; sampled at start.
- start  input  1  begin a run; single-cycle pulse or level.
- stop  input  1  abort the run.
- s0  output  1  select to the gating block, registered.
- s1  output  1  select to the gating block, registered.
- busy  output  1  high while in RUN or GUARD.
- done  output  1  one-cycle pulse when a one-shot run completes.
- step_idx  output  AW  table index currently driven.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - s0=s1=0, busy=0, done=0, step_idx=0, FSM=IDLE.
  - All table entries cleared to 2'b00; latched dwell and loop_en cleared.
- Table writes:
  - prog_we=1 in IDLE writes table[prog_addr]=prog_code on that edge.
  - prog_we is ignored while busy=1.
- States: IDLE, RUN, GUARD (only with the optional feature), DONE.
- IDLE:
  - Outputs are s0=s1=0 and busy=0.
  - start=1 with stop=0: next cycle enter RUN, step_idx=0, {s0,s1}=table[0], busy=1.
  - On entry to RUN, latch the dwell count as max(dwell,1) and latch loop_en.
  - start and stop both high in IDLE: stop wins; stay in IDLE.
- RUN:
  - Each entry's code is presented for exactly Dl cycles, where Dl is the latched count; dwell=0 behaves as 1.
  - A down-counter reloads on each step.
  - At the end of an entry that is not the last, advance step_idx+1 and present the next code on the following cycle, with no gap.
  - At the end of entry DEPTH-1 with loop_en latched 1: wrap step_idx to 0 and continue.
  - At the end of entry DEPTH-1 with loop_en latched 0: enter DONE.
- DONE:
  - Lasts one cycle: done=1, busy=0, s0=s1=0, step_idx=0.
  - Next state is IDLE.
  - A start seen in the DONE cycle is ignored.
- stop in RUN or GUARD:
  - Next cycle enters IDLE with s0=s1=0, step_idx=0, busy=0, and done stays 0.
- start while busy=1 is ignored.
- Changes on dwell or loop_en during a run have no effect until the next start.
- Latency: start at edge N gives the first code on {s0,s1} after edge N+1.
  - A one-shot run asserts done exactly 1 + DEPTH*Dl cycles after start is sampled.
- Reset asserted mid-run has priority over all other inputs: immediate return to the reset values, including the table.

Optional Feature:
- Macro: BLOCK_SEL_SEQ_GUARD_EN.
- Defined:
  - Between two consecutive entries whose codes differ, insert one GUARD cycle with s0=s1=0 (break-before-make on both lanes).
  - step_idx already shows the next index during GUARD; busy stays 1.
  - No guard cycle when consecutive codes are equal, or at the wrap when table[DEPTH-1]==table[0].
  - A stop during GUARD behaves the same as a stop in RUN.
- Not defined:
  - No GUARD state; codes switch back-to-back as described under RUN, and the done timing formula holds exactly.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles -> s0=s1=0, busy=0, done=0, step_idx=0; then start with the table untouched -> {s0,s1}=00 for all 4*Dl cycles.
- One-shot run: program table={01,10,11,00}, dwell=3, loop_en=0, pulse start -> {s0,s1} is 01×3, 10×3, 11×3, 00×3; done pulses for 1 cycle exactly 13 cycles after start; busy falls with done.
- Loop and stop: table={11,01,11,10}, dwell=0, loop_en=1 -> codes change every cycle and wrap 10→11 repeatedly; assert stop mid-run -> next cycle s0=s1=0, busy=0, done never pulses.
- Ignored inputs: issue prog_we to addr 2 with code 00 and a second start while busy -> table[2] is unchanged on the next run and the current run's timing is unaffected; start+stop together in IDLE -> stays IDLE.
- Mid-run reset: rst_n=0 during entry 2 -> next edge gives all outputs 0 and the table cleared; a subsequent start drives 00 throughout.
- Guard cycle (with BLOCK_SEL_SEQ_GUARD_EN): table={11,11,01,01}, dwell=2, loop_en=0 -> 11,11,11,11, one 00 guard cycle, 01,01,01,01; done follows; the run lasts 1 cycle longer than without the macro.

Source files
------------

// File: rtl/block_sel_seq.sv
// block_sel_seq: steps the s0/s1 select pair of the two-lane gating block
// through a small programmed table. Each entry is held for a latched dwell
// count. Runs are one-shot or looping, with a start/stop/busy/done handshake.
// Optional feature macro: BLOCK_SEL_SEQ_GUARD_EN. When it is defined, one
// all-zero guard cycle is inserted between consecutive entries whose codes differ.
// All outputs are registered from the FSM state, so they appear one cycle
// after the state that produces them.
module block_sel_seq #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [1:0]    prog_code,
    input  logic [DW-1:0] dwell,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    output logic          s0,
    output logic          s1,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step_idx
);

`ifdef BLOCK_SEL_SEQ_GUARD_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_GUARD = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`endif

    state_t        state_reg, state_next;
    logic [AW-1:0] idx_reg, idx_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic [DW-1:0] dwell_lat_reg, dwell_lat_next;
    logic          loop_lat_reg, loop_lat_next;

    logic [1:0]    code_reg, code_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic [AW-1:0] step_reg, step_next;

    logic [1:0]    table_reg [DEPTH];

    logic [DW-1:0] dwell_eff;
    logic [AW-1:0] idx_inc;
    logic          last_entry;

    // A zero dwell means one cycle. The index wraps naturally because DEPTH is a power of two.
    assign dwell_eff  = (dwell == '0) ? DW'(1) : dwell;
    assign idx_inc    = idx_reg + 1'b1;
    assign last_entry = (idx_reg == AW'(DEPTH - 1));

    // Table entries: cleared on reset and writable only while the sequencer is idle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
            always_ff @(posedge clk) begin
                if (!rst_n)
                    table_reg[gi] <= 2'b00;
                else if (prog_we && state_reg == ST_IDLE && prog_addr == AW'(gi))
                    table_reg[gi] <= prog_code;
            end
        end
    endgenerate

    // FSM, step index, dwell counter and run configuration latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            dwell_lat_reg <= '0;
            loop_lat_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            dwell_lat_reg <= dwell_lat_next;
            loop_lat_reg  <= loop_lat_next;
        end
    end

    // Next-state logic. A start is refused during the visible done pulse.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        dwell_lat_next = dwell_lat_reg;
        loop_lat_next  = loop_lat_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && !stop && !done_reg) begin
                    state_next     = ST_RUN;
                    idx_next       = '0;
                    dwell_lat_next = dwell_eff;
                    loop_lat_next  = loop_en;
                    cnt_next       = dwell_eff - DW'(1);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    if (last_entry && !loop_lat_reg) begin
                        state_next = ST_DONE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_inc;
                        cnt_next = dwell_lat_reg - DW'(1);
`ifdef BLOCK_SEL_SEQ_GUARD_EN
                        // Break-before-make: only when the code actually changes.
                        if (table_reg[idx_inc] != table_reg[idx_reg])
                            state_next = ST_GUARD;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg - DW'(1);
                end
            end
`ifdef BLOCK_SEL_SEQ_GUARD_EN
            ST_GUARD: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_RUN;
                end
            end
`endif
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode. A stop zeroes the outputs on the same edge that leaves the run.
    always_comb begin
        code_next = 2'b00;
        busy_next = 1'b0;
        done_next = 1'b0;
        step_next = '0;
        case (state_reg)
            ST_RUN: begin
                if (!stop) begin
                    code_next = table_reg[idx_reg];
                    busy_next = 1'b1;
                    step_next = idx_reg;
                end
            end
`ifdef BLOCK_SEL_SEQ_GUARD_EN
            ST_GUARD: begin
                if (!stop) begin
                    busy_next = 1'b1;
                    step_next = idx_reg;
                end
            end
`endif
            ST_DONE: begin
                done_next = 1'b1;
            end
            default: begin
                code_next = 2'b00;
            end
        endcase
    end

    // Registered outputs to the gating block and to the control logic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_reg <= 2'b00;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            step_reg <= '0;
        end else begin
            code_reg <= code_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
            step_reg <= step_next;
        end
    end

    assign s0       = code_reg[1];
    assign s1       = code_reg[0];
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign step_idx = step_reg;

endmodule
